// File: rtl/fifo_shift_buffer.sv
// ============================================================================
// fifo_shift_buffer : edge-triggered shift-register FIFO with occupancy/error flags
// Optional macro FIFO_STICKY_ERR_EN : overflow/underflow latch until rst
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_shift_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trig_write,
  input  logic                  trig_read,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [PTR_WIDTH:0]    count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                 DEPTH     = 2 ** PTR_WIDTH;
  localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] CNT_ONE   = (PTR_WIDTH + 1)'(1);

  logic                  wr_hist_q, rd_hist_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;

  logic wr_ev, rd_ev, push_ok, pop_ok, ovf_evt, udf_evt;

  assign wr_ev = trig_write & ~wr_hist_q;
  assign rd_ev = trig_read  & ~rd_hist_q;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  // A simultaneous read frees the oldest slot, so a push into a full store is legal then.
  assign push_ok = wr_ev & (~full | rd_ev);
  assign pop_ok  = rd_ev & ~empty;
  assign ovf_evt = wr_ev & full & ~rd_ev;
  assign udf_evt = rd_ev & empty;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok)
      count_d = count_q + CNT_ONE;
    else if (!push_ok && pop_ok)
      count_d = count_q - CNT_ONE;
  end

  always_comb begin
    ovf_d = ovf_evt;
    udf_d = udf_evt;
`ifdef FIFO_STICKY_ERR_EN
    ovf_d = ovf_q | ovf_evt;
    udf_d = udf_q | udf_evt;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // History preset high so a strobe held through reset is not seen as an edge.
      wr_hist_q <= 1'b1;
      rd_hist_q <= 1'b1;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      wr_hist_q <= trig_write;
      rd_hist_q <= trig_read;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      if (push_ok) begin
        for (int i = DEPTH - 1; i > 0; i--)
          mem_q[i] <= mem_q[i-1];
        mem_q[0] <= data_in;
      end
    end
  end

  // Oldest word lives at mem_q[count-1]; pops only shrink count.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < DEPTH; i++)
      if (count_q == (PTR_WIDTH + 1)'(i + 1))
        data_out = mem_q[i];
  end

  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_shift_buffer.sv
// ============================================================================
// tb_fifo_shift_buffer : scoreboard bench for fifo_shift_buffer (DEPTH = 4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fifo_shift_buffer;

  localparam int DW    = 8;
  localparam int PW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          trig_write, trig_read;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic [PW:0]   count;
  logic          full, empty, overflow, underflow;

  fifo_shift_buffer #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .trig_write (trig_write),
    .trig_read  (trig_read),
    .data_in    (data_in),
    .data_out   (data_out),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int dout;
    bit ovf;
    bit udf;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model[$];
  bit            m_ovf, m_udf;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.cnt  = model.size();
    e.dout = (model.size() == 0) ? 0 : int'(model[0]);
    e.ovf  = m_ovf;
    e.udf  = m_udf;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_count"},     int'(count),     e.cnt);
    check({tag, "_data_out"},  int'(data_out),  e.dout);
    check({tag, "_full"},      int'(full),      int'(e.cnt == DEPTH));
    check({tag, "_empty"},     int'(empty),     int'(e.cnt == 0));
    check({tag, "_overflow"},  int'(overflow),  int'(e.ovf));
    check({tag, "_underflow"}, int'(underflow), int'(e.udf));
  endtask

  // One strobe pulse (one cycle high) followed by one idle cycle, both checked.
  task automatic do_op(input string tag, input bit w, input bit r, input logic [DW-1:0] d);
    bit is_full, is_empty, ovf_e, udf_e;
    is_full  = (model.size() == DEPTH);
    is_empty = (model.size() == 0);
    ovf_e    = w && is_full && !r;
    udf_e    = r && is_empty;
    if (r && !is_empty) void'(model.pop_front());
    if (w && (!is_full || r)) model.push_back(d);
`ifdef FIFO_STICKY_ERR_EN
    m_ovf = m_ovf | ovf_e;
    m_udf = m_udf | udf_e;
`else
    m_ovf = ovf_e;
    m_udf = udf_e;
`endif
    push_expect();
    @(negedge clk);
    trig_write = w;
    trig_read  = r;
    data_in    = d;
    @(posedge clk); #1;
    check_out(tag);
`ifndef FIFO_STICKY_ERR_EN
    m_ovf = 1'b0;
    m_udf = 1'b0;
`endif
    push_expect();
    @(negedge clk);
    trig_write = 1'b0;
    trig_read  = 1'b0;
    @(posedge clk); #1;
    check_out({tag, "_idle"});
  endtask

  task automatic model_reset();
    model.delete();
    sb.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    trig_write = 1'b1;
    trig_read  = 1'b0;
    data_in    = 8'h55;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Strobe held high across reset release must not push.
    repeat (3) begin
      push_expect();
      @(posedge clk); #1;
      check_out("held_write");
    end
    @(negedge clk);
    trig_write = 1'b0;
    @(posedge clk); #1;
    do_op("first_push", 1'b1, 1'b0, 8'h11);
    do_op("drain_11", 1'b0, 1'b1, 8'h00);

    // Fill, then overflow
    do_op("push_a1", 1'b1, 1'b0, 8'hA1);
    do_op("push_a2", 1'b1, 1'b0, 8'hA2);
    do_op("push_a3", 1'b1, 1'b0, 8'hA3);
    do_op("push_a4", 1'b1, 1'b0, 8'hA4);
    do_op("ovf_a5",  1'b1, 1'b0, 8'hA5);

    // Drain, then underflow
    for (int i = 0; i < 4; i++) do_op($sformatf("pop%0d", i), 1'b0, 1'b1, 8'h00);
    do_op("udf_pop", 1'b0, 1'b1, 8'h00);

    // Simultaneous push+pop mid-occupancy
    do_op("push_b1", 1'b1, 1'b0, 8'hB1);
    do_op("push_b2", 1'b1, 1'b0, 8'hB2);
    do_op("wr_rd_b3", 1'b1, 1'b1, 8'hB3);
    do_op("pop_b2",  1'b0, 1'b1, 8'h00);
    do_op("pop_b3",  1'b0, 1'b1, 8'h00);

    // Simultaneous on empty, then on full
    do_op("wr_rd_empty_c1", 1'b1, 1'b1, 8'hC1);
    do_op("push_c2", 1'b1, 1'b0, 8'hC2);
    do_op("push_c3", 1'b1, 1'b0, 8'hC3);
    do_op("push_c4", 1'b1, 1'b0, 8'hC4);
    do_op("wr_rd_full_c9", 1'b1, 1'b1, 8'hC9);
    for (int i = 0; i < 4; i++) do_op($sformatf("drain_c%0d", i), 1'b0, 1'b1, 8'h00);

    // Async reset at count=3, observed before the next clock edge
    do_op("push_d1", 1'b1, 1'b0, 8'hD1);
    do_op("push_d2", 1'b1, 1'b0, 8'hD2);
    do_op("push_d3", 1'b1, 1'b0, 8'hD3);
    check("pre_rst_count", int'(count), 3);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_count",     int'(count),     0);
    check("async_rst_data_out",  int'(data_out),  0);
    check("async_rst_empty",     int'(empty),     1);
    check("async_rst_full",      int'(full),      0);
    check("async_rst_overflow",  int'(overflow),  0);
    check("async_rst_underflow", int'(underflow), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_op("post_rst_push", 1'b1, 1'b0, 8'hE1);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_shift_buffer.md
Name: fifo_shift_buffer

Overview:
Shift-register data store with occupancy tracking, driven by the same trig_write/trig_read strobes as the FIFO pointer stage. Rising edges of trig_write push data_in; rising edges of trig_read pop the oldest entry. Exposes the head-of-queue word plus count/full/empty and error flags to the downstream communication logic.

Parameters:
DATA_WIDTH, 8, width of each stored word
PTR_WIDTH, 2, log2 of depth; DEPTH = 2**PTR_WIDTH (default 4), legal PTR_WIDTH 1..4

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous, active-high reset
trig_write  input  1  level strobe; rising edge = push request
trig_read  input  1  level strobe; rising edge = pop request
data_in  input  DATA_WIDTH  word pushed on a write event
data_out  output  DATA_WIDTH  oldest stored word (show-ahead); 0 when empty
count  output  PTR_WIDTH+1  occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  push attempted while full
underflow  output  1  pop attempted while empty

Behaviour:
- Reset (async assert, sync release): count=0, all storage=0, data_out=0, empty=1, full=0, overflow=0, underflow=0; both edge-detector history regs set to 1 so a strobe held high through reset does not fire.
- Edge detection: internal registered history per strobe; event in cycle N when strobe=1 and history=0; history <= strobe every cycle. Event acts at the clk edge ending cycle N; data_in sampled at that same edge.
- Storage: mem[0..DEPTH-1]; push shifts mem[i] <= mem[i-1], mem[0] <= data_in. Oldest entry at mem[count-1]. Pop changes only count (no data movement).
- data_out: combinational mux of mem[count-1]; forced 0 when count==0. Valid immediately after the push edge that makes count 1 (latency 1 clk from event cycle).
- full/empty: combinational decode of count.
- Cases per cycle (W=write event, R=read event):
  - none: hold.
  - W only, not full: shift in, count+1.
  - W only, full: ignored, storage and count unchanged, overflow raised.
  - R only, not empty: count-1.
  - R only, empty: ignored, underflow raised.
  - W+R, 0<count<DEPTH: shift in, count unchanged (new word enters, oldest leaves).
  - W+R, full: shift in, count stays DEPTH, no overflow.
  - W+R, empty: push accepted, count=1, read ignored, underflow raised.
- count never wraps; saturates at 0 and DEPTH.
- Reset mid-operation: immediate return to reset state regardless of pending events; stored data lost.

Optional Feature:
FIFO_STICKY_ERR_EN
- Defined: overflow/underflow latch at 1 once raised, cleared only by rst.
- Undefined: overflow/underflow are single-cycle pulses, asserted the clk after the offending event cycle, 0 otherwise.

Test Plan:
- Reset with trig_write held high, release -> no push; count=0, empty=1, data_out=0; drop and re-raise trig_write with data_in=0x11 -> count=1, data_out=0x11.
- Push 0xA1,0xA2,0xA3,0xA4 (DEPTH=4) -> count 1,2,3,4, full=1, data_out stays 0xA1; 5th push 0xA5 -> count=4, contents unchanged, overflow=1 (pulse, or sticky with FIFO_STICKY_ERR_EN).
- From full, 4 pops -> data_out 0xA2,0xA3,0xA4,0 in turn, count 3,2,1,0, empty=1; 5th pop -> underflow=1, count=0.
- count=2 (0xB1,0xB2), simultaneous edges with data_in=0xB3 -> count=2, data_out=0xB2; then pop -> data_out=0xB3.
- Empty, simultaneous edges with data_in=0xC1 -> count=1, data_out=0xC1, underflow=1; full, simultaneous with 0xC9 -> count=4, overflow=0, oldest discarded.
- Assert rst asynchronously mid-sequence at count=3 -> count=0, data_out=0, flags 0 before next clk edge.
